muldiv_iter: RTL and testbench



---
 rtl/muldiv_iter_if.sv | 25 ++
 rtl/muldiv_iter.sv | 176 +++++++++++++++++
 tb/tb_muldiv_iter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_iter_if.sv
// Handshake/data bundle between the CPU controller and the iterative HI/LO unit.
interface muldiv_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [2:0]       mdc;
  logic             start;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;

  modport master (
    output mdc, start, rs_data, rt_data,
    input  hi, lo, busy, stall, done, div_zero
  );

  modport slave (
    input  mdc, start, rs_data, rt_data,
    output hi, lo, busy, stall, done, div_zero
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide,
// one bit per cycle on unsigned magnitudes with sign correction in a final FIX cycle.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_iter_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_e;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } mdc_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               op_div_q, op_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  mdc_e               op;
  logic               is_signed;
  logic               is_div;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo, rem;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    op_div_d   = op_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = div_zero_q;

    op        = mdc_e'(bus.mdc);
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    is_div    = (op == MD_DIV) || (op == MD_DIVU);
    a_neg     = is_signed & bus.rs_data[WIDTH-1];
    b_neg     = is_signed & bus.rt_data[WIDTH-1];
    a_mag     = a_neg ? -bus.rs_data : bus.rs_data;
    b_mag     = b_neg ? -bus.rt_data : bus.rt_data;

    // Multiply: conditional add into the upper half, then shift the whole accumulator right.
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: partial remainder in the upper half, dividend bits leave the top of the lower half
    // while quotient bits enter at its bottom.
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = rem_shift - {1'b0, mcand_q};
    div_next  = div_diff[WIDTH] ? {rem_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

    prod_fix  = neg_res_q ? -acc_q : acc_q;
    quo       = acc_q[WIDTH-1:0];
    rem       = acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              op_div_d   = is_div;
              acc_d      = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
              mcand_d    = is_div ? b_mag : a_mag;
              neg_res_d  = a_neg ^ b_neg;
              neg_rem_d  = a_neg;
              dz_d       = (bus.rt_data == '0);
              div_zero_d = 1'b0;
              cnt_d      = '0;
              state_d    = ST_RUN;
            end
            MD_MTHI: hi_d = bus.rs_data;
            MD_MTLO: lo_d = bus.rs_data;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        acc_d = op_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // A zero divisor leaves the dividend magnitude as remainder, so the usual
        // remainder sign fix already reproduces rs_data in HI.
        if (op_div_q) begin
          lo_d = dz_q ? '1 : (neg_res_q ? -quo : quo);
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        div_zero_d = op_div_q & dz_q;
        done_d     = 1'b1;
        cnt_d      = '0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      mcand_q    <= '0;
      op_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      op_div_q   <= op_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.stall    = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed vector table on a 32-bit unit plus a randomised sweep of an 8-bit unit against an integer model.
module tb_muldiv_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(32)) b32 ();
  muldiv_iter_if #(.WIDTH(8))  b8 ();

  muldiv_iter #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(b32));
  muldiv_iter #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(b8));

  int checks = 0;
  int failures = 0;
  int stall_mism = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[14];

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (b32.stall !== b32.busy || b8.stall !== b8.busy) stall_mism++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output int busy_n);
    b32.mdc = op; b32.start = 1'b1; b32.rs_data = a; b32.rt_data = b;
    @(posedge clk); #1;
    b32.start = 1'b0; b32.mdc = 3'd0;
    lat = 0; busy_n = 0;
    while (b32.done !== 1'b1 && lat < 200) begin
      if (b32.busy === 1'b1) busy_n++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  function automatic logic [16:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, ua, ub, q, r;
    logic [15:0] p;
    sa = $signed(a); sb = $signed(b);
    ua = {24'd0, a}; ub = {24'd0, b};
    p = '0; q = 0; r = 0;
    case (op)
      3'd1: begin p = 16'(sa * sb); return {p, 1'b0}; end
      3'd2: begin p = 16'(ua * ub); return {p, 1'b0}; end
      default: begin
        if (b == 8'd0) return {a, 8'hFF, 1'b1};
        if (op == 3'd3) begin q = sa / sb; r = sa % sb; end
        else            begin q = ua / ub; r = ua % ub; end
        return {8'(r), 8'(q), 1'b0};
      end
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h80;
      2: return 8'hFF;
      3: return 8'h01;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int lat, bn, done_seen;
    logic held;
    logic [31:0] old_hi, old_lo;
    logic [2:0]  op8;
    logic [7:0]  a8, b8v, m_hi, m_lo;
    logic        m_dz;
    logic [16:0] r8;

    vecs[0]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[1]  = '{3'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
    vecs[2]  = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{3'd4, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{3'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
    vecs[6]  = '{3'd4, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};
    vecs[7]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[8]  = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
    vecs[9]  = '{3'd3, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1};
    vecs[10] = '{3'd2, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
    vecs[11] = '{3'd3, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h0000000E, 1'b0};
    vecs[12] = '{3'd4, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
    vecs[13] = '{3'd1, 32'h7FFFFFFF, 32'h00000002, 32'h00000000, 32'hFFFFFFFE, 1'b0};

    rst = 1'b1;
    b32.start = 1'b0; b32.mdc = 3'd0; b32.rs_data = '0; b32.rt_data = '0;
    b8.start  = 1'b0; b8.mdc  = 3'd0; b8.rs_data  = '0; b8.rt_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset hi/lo", {b32.hi, b32.lo}, 64'd0);
    chk("reset flags", {b32.busy, b32.stall, b32.done, b32.div_zero}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      do32(vecs[i].op, vecs[i].a, vecs[i].b, lat, bn);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'd33);
      chk($sformatf("vec%0d busy cycles", i), 64'(bn), 64'd33);
      chk($sformatf("vec%0d hi", i), 64'(b32.hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d lo", i), 64'(b32.lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d div_zero", i), 64'(b32.div_zero), 64'(vecs[i].dz));
      @(posedge clk); #1;
      chk($sformatf("vec%0d done single pulse", i), 64'(b32.done), 64'd0);
    end

    old_lo = b32.lo;
    b32.mdc = 3'd5; b32.start = 1'b1; b32.rs_data = 32'hAAAA5555;
    @(posedge clk); #1;
    b32.start = 1'b0; b32.mdc = 3'd0;
    chk("mthi hi", 64'(b32.hi), 64'h00000000AAAA5555);
    chk("mthi lo kept", 64'(b32.lo), 64'(old_lo));
    chk("mthi no busy/done", {b32.busy, b32.done}, 64'd0);

    // mtlo held on the inputs throughout a mult must wait for the first IDLE edge
    old_hi = b32.hi; old_lo = b32.lo;
    b32.mdc = 3'd1; b32.start = 1'b1; b32.rs_data = 32'h00000003; b32.rt_data = 32'hFFFFFFFC;
    @(posedge clk); #1;
    b32.mdc = 3'd6; b32.rs_data = 32'hCAFEF00D;
    held = 1'b1; lat = 0;
    while (b32.done !== 1'b1 && lat < 200) begin
      if (b32.lo !== old_lo || b32.hi !== old_hi) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    chk("hold hi/lo unchanged while busy", 64'(held), 64'd1);
    chk("hold latency", 64'(lat), 64'd33);
    chk("hold mult result", {b32.hi, b32.lo}, 64'hFFFFFFFF_FFFFFFF4);
    @(posedge clk); #1;
    b32.start = 1'b0; b32.mdc = 3'd0;
    chk("mtlo after done lo", 64'(b32.lo), 64'h00000000CAFEF00D);
    chk("mtlo after done hi", 64'(b32.hi), 64'h00000000FFFFFFFF);
    chk("mtlo after done busy/done", {b32.busy, b32.done}, 64'd0);

    b32.mdc = 3'd4; b32.start = 1'b1; b32.rs_data = 32'h12345678; b32.rt_data = 32'h3;
    @(posedge clk); #1;
    b32.start = 1'b0; b32.mdc = 3'd0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre-reset busy", 64'(b32.busy), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid-op reset hi/lo", {b32.hi, b32.lo}, 64'd0);
    chk("mid-op reset flags", {b32.busy, b32.stall, b32.done, b32.div_zero}, 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (b32.done === 1'b1 || b32.busy === 1'b1) done_seen = 1;
    end
    chk("aborted op stays quiet", 64'(done_seen), 64'd0);
    do32(3'd2, 32'd7, 32'd6, lat, bn);
    chk("multu 7x6 latency", 64'(lat), 64'd33);
    chk("multu 7x6 result", {b32.hi, b32.lo}, 64'd42);

    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    for (int n = 0; n < 400; n++) begin
      op8 = 3'($urandom_range(0, 7));
      a8 = pick8(); b8v = pick8();
      b8.mdc = op8; b8.start = 1'b1; b8.rs_data = a8; b8.rt_data = b8v;
      @(posedge clk); #1;
      b8.start = 1'b0; b8.mdc = 3'd0;
      if (op8 >= 3'd1 && op8 <= 3'd4) begin
        lat = 0;
        while (b8.done !== 1'b1 && lat < 50) begin
          @(posedge clk); #1;
          lat++;
        end
        r8 = ref8(op8, a8, b8v);
        {m_hi, m_lo, m_dz} = r8;
        chk($sformatf("sweep%0d op%0d latency", n, op8), 64'(lat), 64'd9);
      end else if (op8 == 3'd5) begin
        m_hi = a8;
      end else if (op8 == 3'd6) begin
        m_lo = a8;
      end else begin
        chk($sformatf("sweep%0d op%0d no busy", n, op8), 64'(b8.busy), 64'd0);
      end
      chk($sformatf("sweep%0d op%0d a=%0h b=%0h {hi,lo,dz}", n, op8, a8, b8v),
          64'({b8.hi, b8.lo, b8.div_zero}), 64'({m_hi, m_lo, m_dz}));
    end

    chk("stall equals busy every cycle", 64'(stall_mism), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
